// File: rtl/rd_req_pkg.sv
// Shared constants and helpers for the read-request queue.
// Defaults here seed the rd_req_queue parameters.
package rd_req_pkg;

  localparam int DEF_AWIDTH     = 32;
  localparam int DEF_MASTER_NUM = 2;
  localparam int DEF_DEPTH      = 8;
  localparam int MAX_MASTERS    = 16;

  function automatic logic [MAX_MASTERS-1:0] onehot(
    input logic [3:0] idx
  );
    logic [MAX_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// ptr moves just past the winner; it holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    sum     = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (advance && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/rd_req_queue.sv
// Multi-source read-request queue: round-robin push, FWFT pop.
// Each entry carries the address and the one-hot source tag.
module rd_req_queue
  import rd_req_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int MASTER_NUM = DEF_MASTER_NUM,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_LVL  = DEPTH - 2
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [MASTER_NUM-1:0]        s_req,
  input  logic [MASTER_NUM*AWIDTH-1:0] s_addr,
  output logic [MASTER_NUM-1:0]        s_gnt,
  output logic                         m_req,
  output logic [AWIDTH-1:0]            m_addr,
  output logic [MASTER_NUM-1:0]        m_wren,
  input  logic                         m_rd_en,
  output logic                         fifo_full,
  output logic                         fifo_afull,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MASTER_NUM);

  logic [AWIDTH-1:0]     mem_addr [DEPTH];
  logic [MASTER_NUM-1:0] mem_src  [DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  push;
  logic                  pop;
  logic                  advance;
  logic [IW-1:0]         win_idx;
  logic [AWIDTH-1:0]     win_addr;
  logic [MASTER_NUM-1:0] win_oh;

  // Reset must silence grants even though it is asynchronous.
  assign advance = ~fifo_full & ~areset;

  rr_arbiter #(
    .N(MASTER_NUM)
  ) u_arb (
    .clk    (aclk),
    .rst    (areset),
    .req    (s_req),
    .advance(advance),
    .gnt    (s_gnt)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (s_gnt[i]) begin
        win_idx  = IW'(i);
        win_addr = s_addr[i*AWIDTH +: AWIDTH];
      end
    end
    win_oh = MASTER_NUM'(onehot(4'(win_idx)));
  end

  assign m_req  = (count != '0);
  assign push   = |s_gnt;
  assign pop    = m_rd_en & m_req;
  assign m_addr = m_req ? mem_addr[rd_ptr] : '0;
  assign m_wren = m_req ? mem_src[rd_ptr]  : '0;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_addr[wr_ptr] <= win_addr;
      mem_src[wr_ptr]  <= win_oh;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_full     <= 1'b0;
      fifo_afull    <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      fifo_full  <= (count_nxt == CW'(DEPTH));
      fifo_afull <= (count_nxt >= CW'(AFULL_LVL));
      if (m_rd_en && !m_req)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_req_queue.sv
// Bench for rd_req_queue: vector table plus scoreboard model.
// Hand sequences cover first push, underflow and mid-run reset.
module tb_rd_req_queue;

  localparam int AW = 32;
  localparam int MN = 2;
  localparam int DP = 8;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [MN-1:0]  s_req = '0;
  logic [MN*AW-1:0] s_addr = '0;
  logic [MN-1:0]  s_gnt;
  logic           m_req;
  logic [AW-1:0]  m_addr;
  logic [MN-1:0]  m_wren;
  logic           m_rd_en = 1'b0;
  logic           fifo_full;
  logic           fifo_afull;
  logic [3:0]     count;
  logic           underflow_err;

  rd_req_queue #(
    .AWIDTH(AW), .MASTER_NUM(MN), .DEPTH(DP), .AFULL_LVL(DP-2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt),
    .m_req(m_req), .m_addr(m_addr), .m_wren(m_wren),
    .m_rd_en(m_rd_en),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .count(count), .underflow_err(underflow_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  src;
  } ent_t;

  typedef struct {
    logic [1:0] req;
    logic       rd;
    logic [1:0] gnt;
    int         cnt;
    logic       full;
    logic       afull;
  } vec_t;

  ent_t mq[$];
  vec_t tbl[21];
  int   mptr = 0;
  logic merr = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check, model the edge, check state.
  task automatic step(input logic [1:0] req, input logic [31:0] a0,
                      input logic [31:0] a1, input logic rd,
                      output logic [1:0] og, output int oc,
                      output logic of, output logic oa);
    logic [1:0] eg;
    int         w;
    s_req   = req;
    s_addr  = {a1, a0};
    m_rd_en = rd;
    #1;
    eg = 2'b00;
    w  = -1;
    if (mq.size() != DP && req != 2'b00) begin
      w  = req[mptr] ? mptr : 1 - mptr;
      eg = 2'b01 << w;
    end
    chk("s_gnt", s_gnt, eg);
    og = s_gnt;
    chk("m_req", m_req, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_addr", m_addr, mq[0].addr);
      chk("m_wren", m_wren, mq[0].src);
    end else begin
      chk("m_addr_zero", m_addr, 0);
      chk("m_wren_zero", m_wren, 0);
    end
    if (rd) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else merr = 1'b1;
    end
    if (w >= 0) begin
      mq.push_back('{addr: (w == 0) ? a0 : a1, src: eg});
      mptr = (w + 1) % MN;
    end
    @(posedge aclk);
    #1;
    chk("count", count, mq.size());
    chk("fifo_full", fifo_full, mq.size() == DP);
    chk("fifo_afull", fifo_afull, mq.size() >= DP - 2);
    chk("underflow_err", underflow_err, merr);
    oc = count;
    of = fifo_full;
    oa = fifo_afull;
    @(negedge aclk);
  endtask

  task automatic pulse_reset();
    s_req   = 2'b11;
    m_rd_en = 1'b0;
    areset  = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_afull", fifo_afull, 0);
    chk("rst_gnt", s_gnt, 0);
    chk("rst_uflow", underflow_err, 0);
    mq.delete();
    mptr = 0;
    merr = 1'b0;
    s_req = 2'b00;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    int         c;
    logic       f;
    logic       a;

    tbl[0]  = '{2'b11, 1'b0, 2'b01, 1, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 2'b10, 2, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b0, 2'b01, 3, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 1'b0, 2'b10, 4, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 1'b0, 2'b01, 5, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b0, 2'b10, 6, 1'b0, 1'b1};
    tbl[6]  = '{2'b11, 1'b0, 2'b01, 7, 1'b0, 1'b1};
    tbl[7]  = '{2'b11, 1'b0, 2'b10, 8, 1'b1, 1'b1};
    tbl[8]  = '{2'b11, 1'b0, 2'b00, 8, 1'b1, 1'b1};
    tbl[9]  = '{2'b11, 1'b1, 2'b00, 7, 1'b0, 1'b1};
    tbl[10] = '{2'b11, 1'b0, 2'b01, 8, 1'b1, 1'b1};
    tbl[11] = '{2'b00, 1'b1, 2'b00, 7, 1'b0, 1'b1};
    tbl[12] = '{2'b00, 1'b1, 2'b00, 6, 1'b0, 1'b1};
    tbl[13] = '{2'b00, 1'b1, 2'b00, 5, 1'b0, 1'b0};
    tbl[14] = '{2'b00, 1'b1, 2'b00, 4, 1'b0, 1'b0};
    tbl[15] = '{2'b00, 1'b1, 2'b00, 3, 1'b0, 1'b0};
    tbl[16] = '{2'b01, 1'b1, 2'b01, 3, 1'b0, 1'b0};
    tbl[17] = '{2'b00, 1'b1, 2'b00, 2, 1'b0, 1'b0};
    tbl[18] = '{2'b00, 1'b1, 2'b00, 1, 1'b0, 1'b0};
    tbl[19] = '{2'b00, 1'b1, 2'b00, 0, 1'b0, 1'b0};
    tbl[20] = '{2'b00, 1'b1, 2'b00, 0, 1'b0, 1'b0};

    repeat (2) @(negedge aclk);
    pulse_reset();

    step(2'b01, 32'h1000, 32'h0, 1'b0, g, c, f, a);
    chk("first_gnt", g, 2'b01);
    chk("first_m_req", m_req, 1);
    chk("first_m_addr", m_addr, 32'h1000);
    chk("first_m_wren", m_wren, 2'b01);
    chk("first_count", c, 1);
    step(2'b00, 32'h0, 32'h0, 1'b0, g, c, f, a);
    chk("first_gnt_once", g, 2'b00);

    pulse_reset();
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].req, 32'h100 + i, 32'h200 + i, tbl[i].rd,
           g, c, f, a);
      chk($sformatf("tbl%0d_gnt", i), g, tbl[i].gnt);
      chk($sformatf("tbl%0d_cnt", i), c, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), f, tbl[i].full);
      chk($sformatf("tbl%0d_afull", i), a, tbl[i].afull);
    end
    chk("uflow_set", underflow_err, 1);
    step(2'b00, 32'h0, 32'h0, 1'b0, g, c, f, a);
    chk("uflow_sticky", underflow_err, 1);
    chk("uflow_count", c, 0);

    for (int i = 0; i < 5; i++)
      step(2'b01, 32'h500 + i, 32'h600 + i, 1'b0, g, c, f, a);
    chk("pre_rst_count", c, 5);
    pulse_reset();

    step(2'b11, 32'h2000, 32'h3000, 1'b0, g, c, f, a);
    chk("post_rst_gnt", g, 2'b01);
    chk("post_rst_head", m_addr, 32'h2000);
    step(2'b00, 32'h0, 32'h0, 1'b1, g, c, f, a);
    chk("post_rst_empty", c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
